// File: rtl/iic_sineana_pkg.sv
// Shared definitions for the sine generator analyzer.
// FSM state encoding and default widths and thresholds.
package iic_sineana_pkg;

    localparam int BW_DEF    = 16;
    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int HYST_DEF  = 64;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEEK    = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

endpackage

// File: rtl/iic_sineana_if.sv
// Generator sample input, read strobe, analyzer control and results.
// master drives samples and control, slave is the analyzer.
interface iic_sineana_if #(
    parameter int BW    = iic_sineana_pkg::BW_DEF,
    parameter int DIV_W = iic_sineana_pkg::DIV_W_DEF,
    parameter int CNT_W = iic_sineana_pkg::CNT_W_DEF
);

    logic signed [BW-1:0] data_i;
    logic                 data_rd_o;
    logic                 tst_ana_en_i;
    logic [DIV_W-1:0]     tst_ana_div_i;
    logic                 clr_i;
    logic signed [BW-1:0] peak_pos_o;
    logic signed [BW-1:0] peak_neg_o;
    logic [CNT_W-1:0]     period_o;
    logic [CNT_W-1:0]     zc_cnt_o;
    logic                 valid_o;

    modport master (
        output data_i,
        output tst_ana_en_i,
        output tst_ana_div_i,
        output clr_i,
        input  data_rd_o,
        input  peak_pos_o,
        input  peak_neg_o,
        input  period_o,
        input  zc_cnt_o,
        input  valid_o
    );

    modport slave (
        input  data_i,
        input  tst_ana_en_i,
        input  tst_ana_div_i,
        input  clr_i,
        output data_rd_o,
        output peak_pos_o,
        output peak_neg_o,
        output period_o,
        output zc_cnt_o,
        output valid_o
    );

endinterface

// File: rtl/iic_sineana_div.sv
// Read-interval divider: strobes once every div+1 enabled cycles.
// The compare is live, so a new div lower than the count wraps around.
module iic_sineana_div
    import iic_sineana_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             rd
);

    logic [DIV_W-1:0] cnt_q;
    logic             hit;

    assign hit = (cnt_q == div);
    assign rd  = en & hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else if (hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/iic_sineana.sv
// Sine analyzer: peaks, rising zero crossings and period in reads.
// Define IIC_SINEANA_HYST_EN for hysteresis-based crossing detection.
module iic_sineana
    import iic_sineana_pkg::*;
#(
    parameter int BW    = BW_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int HYST  = HYST_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    iic_sineana_if.slave  bus
);

    if (HYST < 0) begin : g_bad_hyst
        $error("HYST must be non-negative");
    end

    logic                 rd;
    logic                 en;
    logic                 clr;
    logic                 xing;
    logic signed [BW-1:0] sample;

    state_t               state_q;
    logic signed [BW-1:0] peak_pos_q;
    logic signed [BW-1:0] peak_neg_q;
    logic [CNT_W-1:0]     period_q;
    logic [CNT_W-1:0]     zc_q;
    logic [CNT_W-1:0]     count_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     count_inc;
    logic [CNT_W-1:0]     zc_inc;

    assign en     = bus.tst_ana_en_i;
    assign clr    = bus.clr_i;
    assign sample = bus.data_i;

    iic_sineana_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (en),
        .div   (bus.tst_ana_div_i),
        .rd    (rd)
    );

`ifdef IIC_SINEANA_HYST_EN
    localparam logic signed [BW-1:0] H_POS = BW'(HYST);
    localparam logic signed [BW-1:0] H_NEG = BW'(-HYST);

    logic arm_q;

    assign xing = arm_q && (sample >= H_POS);

    // Arm tracks every read, clear included, like the plain edge detector
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arm_q <= 1'b0;
        end else if (rd) begin
            if (xing) begin
                arm_q <= 1'b0;
            end else if (sample < H_NEG) begin
                arm_q <= 1'b1;
            end
        end
    end
`else
    logic signed [BW-1:0] prev_q;

    assign xing = prev_q[BW-1] && !sample[BW-1];

    // Loads on every read, even one swallowed by a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else if (rd) begin
            prev_q <= sample;
        end
    end
`endif

    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
    assign zc_inc    = (&zc_q) ? zc_q : zc_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            peak_pos_q <= '0;
            peak_neg_q <= '0;
            period_q   <= '0;
            zc_q       <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else if (clr) begin
            state_q    <= en ? SEEK : IDLE;
            peak_pos_q <= '0;
            peak_neg_q <= '0;
            period_q   <= '0;
            zc_q       <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else if (!en) begin
            state_q <= IDLE;
        end else begin
            if (rd) begin
                if (sample > peak_pos_q) begin
                    peak_pos_q <= sample;
                end
                if (sample < peak_neg_q) begin
                    peak_neg_q <= sample;
                end
            end
            unique case (state_q)
                IDLE: begin
                    state_q <= SEEK;
                end
                SEEK: begin
                    if (rd && xing) begin
                        state_q <= MEASURE;
                        count_q <= CNT_W'(1);
                        zc_q    <= zc_inc;
                    end
                end
                MEASURE: begin
                    if (rd) begin
                        if (xing) begin
                            period_q <= count_q;
                            valid_q  <= 1'b1;
                            count_q  <= CNT_W'(1);
                            zc_q     <= zc_inc;
                        end else begin
                            count_q <= count_inc;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_rd_o  = rd;
    assign bus.peak_pos_o = peak_pos_q;
    assign bus.peak_neg_o = peak_neg_q;
    assign bus.period_o   = period_q;
    assign bus.zc_cnt_o   = zc_q;
    assign bus.valid_o    = valid_q;

endmodule

// File: tb/tb_iic_sineana.sv
// Directed bench for iic_sineana with a 64-entry sine generator model.
// Honours IIC_SINEANA_HYST_EN for the noise-rejection expectations.
module tb_iic_sineana;
    import iic_sineana_pkg::*;

    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iic_sineana_if #(
        .BW    (16),
        .DIV_W (8),
        .CNT_W (16)
    ) bus ();

    iic_sineana #(
        .BW    (16),
        .DIV_W (8),
        .CNT_W (16),
        .HYST  (64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int                 sine_tbl [64];
    logic [5:0]         idx;
    logic [5:0]         step;
    logic               man_mode;
    logic signed [15:0] man_data;
    int                 rd_cnt;
    int                 checks = 0;
    int                 errors = 0;

    assign bus.data_i = man_mode ? man_data : 16'(sine_tbl[idx]);

    initial begin
        for (int k = 0; k < 64; k++) begin
            real v;
            v = 0.9 * 32767.0 * $sin(2.0 * PI * k / 64.0);
            if (v >= 0.0) sine_tbl[k] = $rtoi(v + 0.5);
            else sine_tbl[k] = -$rtoi(0.5 - v);
        end
    end

    // Generator advances and reads are counted on each strobe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            rd_cnt <= 0;
        end else if (bus.data_rd_o) begin
            idx    <= idx + step;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic feed(input int v, input logic c);
        man_data   = 16'(v);
        bus.clr_i  = c;
        @(negedge clk);
        bus.clr_i  = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.valid_o) break;
        end
    endtask

    initial begin
        int seen;
        int first;
        rst               = 1'b1;
        bus.tst_ana_en_i  = 1'b0;
        bus.tst_ana_div_i = '0;
        bus.clr_i         = 1'b0;
        man_mode          = 1'b0;
        man_data          = '0;
        step              = 6'd1;
        @(negedge clk);
        @(negedge clk);

        chk("rst_rd", int'(bus.data_rd_o), 0);
        chk("rst_pos", int'(bus.peak_pos_o), 0);
        chk("rst_neg", int'(bus.peak_neg_o), 0);
        chk("rst_period", int'(bus.period_o), 0);
        chk("rst_zc", int'(bus.zc_cnt_o), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_state", int'(dut.state_q), int'(IDLE));

        // Step 1, read every cycle
        rst              = 1'b0;
        bus.tst_ana_en_i = 1'b1;
        wait_valid(400);
        chk("s1_valid", int'(bus.valid_o), 1);
        chk("s1_reads", rd_cnt, 129);
        chk("s1_period", int'(bus.period_o), 64);
        chk("s1_zc", int'(bus.zc_cnt_o), 2);
        chk("s1_pos", int'(bus.peak_pos_o), 29490);
        chk("s1_neg", int'(bus.peak_neg_o), -29490);

        // Disable mid-measure for 10 cycles
        bus.tst_ana_en_i = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.data_rd_o) seen++;
        end
        chk("dis_rd", seen, 0);
        chk("dis_reads", rd_cnt, 129);
        chk("dis_period", int'(bus.period_o), 64);
        chk("dis_zc", int'(bus.zc_cnt_o), 2);
        chk("dis_valid", int'(bus.valid_o), 1);
        chk("dis_pos", int'(bus.peak_pos_o), 29490);
        chk("dis_state", int'(dut.state_q), int'(IDLE));

        bus.tst_ana_en_i = 1'b1;
        @(negedge clk);
        chk("re_state", int'(dut.state_q), int'(SEEK));
        chk("re_valid", int'(bus.valid_o), 1);
        repeat (199) @(negedge clk);
        chk("re_reads", rd_cnt, 329);
        chk("re_zc", int'(bus.zc_cnt_o), 5);
        chk("re_period", int'(bus.period_o), 64);

        // Step 4, div 3
        bus.tst_ana_en_i = 1'b0;
        rst_pulse();
        step              = 6'd4;
        bus.tst_ana_div_i = 8'd3;
        bus.tst_ana_en_i  = 1'b1;
        repeat (40) @(negedge clk);
        chk("d3_reads40", rd_cnt, 10);
        wait_valid(400);
        chk("d3_valid", int'(bus.valid_o), 1);
        chk("d3_reads", rd_cnt, 33);
        chk("d3_period", int'(bus.period_o), 16);
        chk("d3_pos", int'(bus.peak_pos_o), 29490);
        chk("d3_neg", int'(bus.peak_neg_o), -29490);

        // Clear coincident with a crossing read
        rst_pulse();
        bus.tst_ana_div_i = 8'd0;
        man_mode          = 1'b1;
        feed(-100, 1'b0);
        feed(100, 1'b0);
        feed(-100, 1'b0);
        feed(-100, 1'b0);
        feed(100, 1'b0);
        feed(-100, 1'b0);
        feed(-100, 1'b0);
        chk("pc_period", int'(bus.period_o), 3);
        chk("pc_valid", int'(bus.valid_o), 1);
        chk("pc_zc", int'(bus.zc_cnt_o), 2);
        feed(100, 1'b1);
        chk("clr_pos", int'(bus.peak_pos_o), 0);
        chk("clr_neg", int'(bus.peak_neg_o), 0);
        chk("clr_period", int'(bus.period_o), 0);
        chk("clr_zc", int'(bus.zc_cnt_o), 0);
        chk("clr_valid", int'(bus.valid_o), 0);
        chk("clr_state", int'(dut.state_q), int'(SEEK));
        feed(-100, 1'b0);
        feed(-100, 1'b0);
        feed(100, 1'b0);
        feed(-100, 1'b0);
        feed(-100, 1'b0);
        feed(-100, 1'b0);
        feed(100, 1'b0);
        chk("ac_period", int'(bus.period_o), 4);
        chk("ac_zc", int'(bus.zc_cnt_o), 2);
        chk("ac_valid", int'(bus.valid_o), 1);
        chk("ac_pos", int'(bus.peak_pos_o), 100);
        chk("ac_neg", int'(bus.peak_neg_o), -100);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pos", int'(bus.peak_pos_o), 0);
        chk("ar_neg", int'(bus.peak_neg_o), 0);
        chk("ar_period", int'(bus.period_o), 0);
        chk("ar_zc", int'(bus.zc_cnt_o), 0);
        chk("ar_valid", int'(bus.valid_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Small noise around zero
        for (int i = 0; i < 20; i++) begin
            feed((i % 2 == 0) ? -40 : 40, 1'b0);
        end
`ifdef IIC_SINEANA_HYST_EN
        chk("noise_zc", int'(bus.zc_cnt_o), 0);
`else
        chk("noise_zc", int'(bus.zc_cnt_o), 10);
`endif
        feed(-100, 1'b0);
        feed(100, 1'b0);
`ifdef IIC_SINEANA_HYST_EN
        chk("big_zc", int'(bus.zc_cnt_o), 1);
`else
        chk("big_zc", int'(bus.zc_cnt_o), 11);
`endif

        // Divider lowered below the running count
        man_mode = 1'b0;
        rst_pulse();
        bus.tst_ana_div_i = 8'd5;
        repeat (4) @(negedge clk);
        chk("dv_pre_rd", int'(bus.data_rd_o), 0);
        bus.tst_ana_div_i = 8'd2;
        first = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.data_rd_o) begin
                first = k;
                break;
            end
        end
        chk("dv_wrap", first, 254);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_sineana.md
IIC_SINEANA -- requirements
Module: iic_sineana

Interface
REQ-001 Parameter BW, default 16: width of the signed sample input and the peak outputs.
REQ-002 Parameter DIV_W, default 8: width of the read-interval divider setting.
REQ-003 Parameter CNT_W, default 16: width of the period and crossing counters.
REQ-004 Parameter HYST, default 64: crossing hysteresis threshold in LSB (used only under IIC_SINEANA_HYST_EN).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, as listed in REQ-006 and REQ-007.
REQ-006 clk_i  in  1  single clock, posedge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 data_i  in  BW signed  current sample from the sine generator.
REQ-009 data_rd_o  out  1  one-cycle read strobe that advances the generator.
REQ-010 tst_ana_en_i  in  1  analyzer enable.
REQ-011 tst_ana_div_i  in  DIV_W  read interval minus 1, in clock cycles.
REQ-012 clr_i  in  1  synchronous clear of statistics.
REQ-013 peak_pos_o / peak_neg_o  out  BW signed  maximum / minimum captured sample.
REQ-014 period_o  out  CNT_W  reads between the last two rising zero crossings.
REQ-015 zc_cnt_o  out  CNT_W  count of rising zero crossings.
REQ-016 valid_o  out  1  period_o holds a complete measurement.

Function
REQ-017 Divider: while enabled, it SHALL count 0..tst_ana_div_i and assert data_rd_o in the cycle the count equals tst_ana_div_i; a setting of 0 gives a strobe every cycle.
REQ-018 Sample capture: data_i SHALL be sampled on the clock edge on which data_rd_o is high, i.e. before the generator advances.
REQ-019 Rising crossing (default): previous sample < 0 and current sample >= 0; the previous-sample register SHALL reset to 0.
REQ-020 FSM states: IDLE, SEEK, MEASURE.
- IDLE -> SEEK when enabled.
- SEEK -> MEASURE on the first crossing; count <= 1.
- MEASURE, non-crossing read: count++ (saturating at all-ones).
- MEASURE, crossing read: period_o <= count, valid_o <= 1, count <= 1.
REQ-021 Every captured sample SHALL update peak_pos_o = max(peak_pos_o, sample) and peak_neg_o = min(peak_neg_o, sample).
REQ-022 zc_cnt_o SHALL increment on each rising crossing in SEEK or MEASURE and saturate at all-ones.
REQ-023 On tst_ana_en_i low:
- divider held at 0, data_rd_o low;
- FSM -> IDLE;
- peak, period, zc and valid outputs held.
REQ-024 On clr_i:
- clears peaks, period_o, zc_cnt_o, valid_o and count;
- FSM -> SEEK if enabled, else IDLE;
- clear wins over a simultaneous read, but that read still loads the previous-sample register.
REQ-025 A change of tst_ana_div_i mid-count SHALL take effect at the next comparison; a count already above the new value SHALL wrap through all-ones to 0.

Reset
REQ-026 Under rst_i, all outputs, the divider, count and previous sample SHALL be 0, and the FSM SHALL be IDLE, regardless of clock.

Configuration
REQ-027 Macro IIC_SINEANA_HYST_EN.
- Defined: an arm flag is set by a sample < -HYST; a crossing requires armed and sample >= +HYST, then clears the arm flag.
- Undefined: REQ-019 detection applies, with no arm logic.

Structure
REQ-028 Package iic_sineana_pkg SHALL hold the FSM state typedef and the default BW, DIV_W, CNT_W and HYST constants.
REQ-029 Sub-module iic_sineana_div SHALL implement the read-interval divider and strobe.

Verification
REQ-030 With the generator as source (BW=16, 64-entry table, 0.9 amplitude, step 1), div=0, enable: reads every cycle; valid_o rises after read 129; period_o=64.
REQ-031 Generator step 4, div=3: data_rd_o every 4th cycle; period_o=16; peak_pos_o=29490; peak_neg_o=-29490.
REQ-032 Drop tst_ana_en_i mid-MEASURE for 10 cycles: data_rd_o stays 0 and outputs are held; on re-enable the FSM re-SEEKs and valid_o stays 1.
REQ-033 Assert clr_i on the same cycle as a crossing read: all stats are 0, valid_o=0, the FSM is in SEEK, and the next period is measured correctly.
REQ-034 Assert rst_i asynchronously between clock edges: outputs are 0 immediately.
REQ-035 With HYST_EN and HYST=64, drive a ±40 LSB noise sequence: zc_cnt_o remains 0; without HYST_EN, zc_cnt_o is nonzero.
